// File: rtl/vga_mem_arbiter.sv
// Two-to-one AXI4 arbiter sharing one memory master port between the VGA
// fetch engine (port 0, priority) and the offset-map/CPU path (port 1).
module vga_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int ID_W         = 4
) (
    input  logic                clock,
    input  logic                reset,
    // port 0
    input  logic                io_in0_awvalid,
    output logic                io_in0_awready,
    input  logic [ADDR_W-1:0]   io_in0_awaddr,
    input  logic [ID_W-1:0]     io_in0_awid,
    input  logic [7:0]          io_in0_awlen,
    input  logic [2:0]          io_in0_awsize,
    input  logic [1:0]          io_in0_awburst,
    input  logic                io_in0_wvalid,
    output logic                io_in0_wready,
    input  logic [DATA_W-1:0]   io_in0_wdata,
    input  logic [DATA_W/8-1:0] io_in0_wstrb,
    input  logic                io_in0_wlast,
    output logic                io_in0_bvalid,
    input  logic                io_in0_bready,
    output logic [1:0]          io_in0_bresp,
    output logic [ID_W-1:0]     io_in0_bid,
    input  logic                io_in0_arvalid,
    output logic                io_in0_arready,
    input  logic [ADDR_W-1:0]   io_in0_araddr,
    input  logic [ID_W-1:0]     io_in0_arid,
    input  logic [7:0]          io_in0_arlen,
    input  logic [2:0]          io_in0_arsize,
    input  logic [1:0]          io_in0_arburst,
    output logic                io_in0_rvalid,
    input  logic                io_in0_rready,
    output logic [1:0]          io_in0_rresp,
    output logic [DATA_W-1:0]   io_in0_rdata,
    output logic                io_in0_rlast,
    output logic [ID_W-1:0]     io_in0_rid,
    // port 1
    input  logic                io_in1_awvalid,
    output logic                io_in1_awready,
    input  logic [ADDR_W-1:0]   io_in1_awaddr,
    input  logic [ID_W-1:0]     io_in1_awid,
    input  logic [7:0]          io_in1_awlen,
    input  logic [2:0]          io_in1_awsize,
    input  logic [1:0]          io_in1_awburst,
    input  logic                io_in1_wvalid,
    output logic                io_in1_wready,
    input  logic [DATA_W-1:0]   io_in1_wdata,
    input  logic [DATA_W/8-1:0] io_in1_wstrb,
    input  logic                io_in1_wlast,
    output logic                io_in1_bvalid,
    input  logic                io_in1_bready,
    output logic [1:0]          io_in1_bresp,
    output logic [ID_W-1:0]     io_in1_bid,
    input  logic                io_in1_arvalid,
    output logic                io_in1_arready,
    input  logic [ADDR_W-1:0]   io_in1_araddr,
    input  logic [ID_W-1:0]     io_in1_arid,
    input  logic [7:0]          io_in1_arlen,
    input  logic [2:0]          io_in1_arsize,
    input  logic [1:0]          io_in1_arburst,
    output logic                io_in1_rvalid,
    input  logic                io_in1_rready,
    output logic [1:0]          io_in1_rresp,
    output logic [DATA_W-1:0]   io_in1_rdata,
    output logic                io_in1_rlast,
    output logic [ID_W-1:0]     io_in1_rid,
    // memory side
    output logic                io_out_awvalid,
    input  logic                io_out_awready,
    output logic [ADDR_W-1:0]   io_out_awaddr,
    output logic [ID_W-1:0]     io_out_awid,
    output logic [7:0]          io_out_awlen,
    output logic [2:0]          io_out_awsize,
    output logic [1:0]          io_out_awburst,
    output logic                io_out_wvalid,
    input  logic                io_out_wready,
    output logic [DATA_W-1:0]   io_out_wdata,
    output logic [DATA_W/8-1:0] io_out_wstrb,
    output logic                io_out_wlast,
    input  logic                io_out_bvalid,
    output logic                io_out_bready,
    input  logic [1:0]          io_out_bresp,
    input  logic [ID_W-1:0]     io_out_bid,
    output logic                io_out_arvalid,
    input  logic                io_out_arready,
    output logic [ADDR_W-1:0]   io_out_araddr,
    output logic [ID_W-1:0]     io_out_arid,
    output logic [7:0]          io_out_arlen,
    output logic [2:0]          io_out_arsize,
    output logic [1:0]          io_out_arburst,
    input  logic                io_out_rvalid,
    output logic                io_out_rready,
    input  logic [1:0]          io_out_rresp,
    input  logic [DATA_W-1:0]   io_out_rdata,
    input  logic                io_out_rlast,
    input  logic [ID_W-1:0]     io_out_rid,
    output logic                io_busy,
    output logic                io_grant
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic req0, req1, pick1, pick_wr;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req0    = io_in0_awvalid | io_in0_arvalid;
    assign req1    = io_in1_awvalid | io_in1_arvalid;
    assign pick1   = req1 & ((starve_cnt_q == CNT_MAX) | ~req0);
    assign pick_wr = pick1 ? io_in1_awvalid : io_in0_awvalid;

    assign ar_hs = io_out_arvalid & io_out_arready;
    assign r_hs  = io_out_rvalid  & io_out_rready;
    assign aw_hs = io_out_awvalid & io_out_awready;
    assign w_hs  = io_out_wvalid  & io_out_wready;
    assign b_hs  = io_out_bvalid  & io_out_bready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = pick1;
                    state_d = pick_wr ? WR_ADDR : RD_ADDR;
                    // only port-0 wins over a waiting port 1 count
                    if (pick1 | ~req1)
                        starve_cnt_d = '0;
                    else if (starve_cnt_q != CNT_MAX)
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs & io_out_rlast) state_d = IDLE;
            WR_ADDR: if (aw_hs) state_d = WR_DATA;
            WR_DATA: if (w_hs & io_out_wlast) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_out_awvalid = 1'b0;
        io_out_wvalid  = 1'b0;
        io_out_bready  = 1'b0;
        io_out_arvalid = 1'b0;
        io_out_rready  = 1'b0;
        io_in0_awready = 1'b0;
        io_in0_wready  = 1'b0;
        io_in0_bvalid  = 1'b0;
        io_in0_arready = 1'b0;
        io_in0_rvalid  = 1'b0;
        io_in1_awready = 1'b0;
        io_in1_wready  = 1'b0;
        io_in1_bvalid  = 1'b0;
        io_in1_arready = 1'b0;
        io_in1_rvalid  = 1'b0;
        unique case (state_q)
            RD_ADDR: begin
                io_out_arvalid = grant_q ? io_in1_arvalid : io_in0_arvalid;
                io_in0_arready = ~grant_q & io_out_arready;
                io_in1_arready =  grant_q & io_out_arready;
            end
            RD_DATA: begin
                io_out_rready = grant_q ? io_in1_rready : io_in0_rready;
                io_in0_rvalid = ~grant_q & io_out_rvalid;
                io_in1_rvalid =  grant_q & io_out_rvalid;
            end
            WR_ADDR: begin
                io_out_awvalid = grant_q ? io_in1_awvalid : io_in0_awvalid;
                io_in0_awready = ~grant_q & io_out_awready;
                io_in1_awready =  grant_q & io_out_awready;
            end
            WR_DATA: begin
                io_out_wvalid = grant_q ? io_in1_wvalid : io_in0_wvalid;
                io_in0_wready = ~grant_q & io_out_wready;
                io_in1_wready =  grant_q & io_out_wready;
            end
            WR_RESP: begin
                io_out_bready = grant_q ? io_in1_bready : io_in0_bready;
                io_in0_bvalid = ~grant_q & io_out_bvalid;
                io_in1_bvalid =  grant_q & io_out_bvalid;
            end
            default: ;
        endcase
    end

    assign io_out_awaddr  = grant_q ? io_in1_awaddr  : io_in0_awaddr;
    assign io_out_awid    = grant_q ? io_in1_awid    : io_in0_awid;
    assign io_out_awlen   = grant_q ? io_in1_awlen   : io_in0_awlen;
    assign io_out_awsize  = grant_q ? io_in1_awsize  : io_in0_awsize;
    assign io_out_awburst = grant_q ? io_in1_awburst : io_in0_awburst;
    assign io_out_wdata   = grant_q ? io_in1_wdata   : io_in0_wdata;
    assign io_out_wstrb   = grant_q ? io_in1_wstrb   : io_in0_wstrb;
    assign io_out_wlast   = grant_q ? io_in1_wlast   : io_in0_wlast;
    assign io_out_araddr  = grant_q ? io_in1_araddr  : io_in0_araddr;
    assign io_out_arid    = grant_q ? io_in1_arid    : io_in0_arid;
    assign io_out_arlen   = grant_q ? io_in1_arlen   : io_in0_arlen;
    assign io_out_arsize  = grant_q ? io_in1_arsize  : io_in0_arsize;
    assign io_out_arburst = grant_q ? io_in1_arburst : io_in0_arburst;

    // response payloads are broadcast; only the valids are steered
    assign io_in0_bresp = io_out_bresp;
    assign io_in0_bid   = io_out_bid;
    assign io_in0_rresp = io_out_rresp;
    assign io_in0_rdata = io_out_rdata;
    assign io_in0_rlast = io_out_rlast;
    assign io_in0_rid   = io_out_rid;
    assign io_in1_bresp = io_out_bresp;
    assign io_in1_bid   = io_out_bid;
    assign io_in1_rresp = io_out_rresp;
    assign io_in1_rdata = io_out_rdata;
    assign io_in1_rlast = io_out_rlast;
    assign io_in1_rid   = io_out_rid;

    assign io_busy  = (state_q != IDLE);
    assign io_grant = grant_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: table of single transactions plus hand-written
// priority, contention, reset and idle sequences, checked via queues.
module tb_vga_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_awvalid [2];
    logic        in_awready [2];
    logic [31:0] in_awaddr  [2];
    logic [3:0]  in_awid    [2];
    logic [7:0]  in_awlen   [2];
    logic [2:0]  in_awsize  [2];
    logic [1:0]  in_awburst [2];
    logic        in_wvalid  [2];
    logic        in_wready  [2];
    logic [63:0] in_wdata   [2];
    logic [7:0]  in_wstrb   [2];
    logic        in_wlast   [2];
    logic        in_bvalid  [2];
    logic        in_bready  [2];
    logic [1:0]  in_bresp   [2];
    logic [3:0]  in_bid     [2];
    logic        in_arvalid [2];
    logic        in_arready [2];
    logic [31:0] in_araddr  [2];
    logic [3:0]  in_arid    [2];
    logic [7:0]  in_arlen   [2];
    logic [2:0]  in_arsize  [2];
    logic [1:0]  in_arburst [2];
    logic        in_rvalid  [2];
    logic        in_rready  [2];
    logic [1:0]  in_rresp   [2];
    logic [63:0] in_rdata   [2];
    logic        in_rlast   [2];
    logic [3:0]  in_rid     [2];

    logic        io_out_awvalid, io_out_awready;
    logic [31:0] io_out_awaddr;
    logic [3:0]  io_out_awid;
    logic [7:0]  io_out_awlen;
    logic [2:0]  io_out_awsize;
    logic [1:0]  io_out_awburst;
    logic        io_out_wvalid, io_out_wready;
    logic [63:0] io_out_wdata;
    logic [7:0]  io_out_wstrb;
    logic        io_out_wlast;
    logic        io_out_bvalid, io_out_bready;
    logic [1:0]  io_out_bresp;
    logic [3:0]  io_out_bid;
    logic        io_out_arvalid, io_out_arready;
    logic [31:0] io_out_araddr;
    logic [3:0]  io_out_arid;
    logic [7:0]  io_out_arlen;
    logic [2:0]  io_out_arsize;
    logic [1:0]  io_out_arburst;
    logic        io_out_rvalid, io_out_rready;
    logic [1:0]  io_out_rresp;
    logic [63:0] io_out_rdata;
    logic        io_out_rlast;
    logic [3:0]  io_out_rid;
    logic        io_busy, io_grant;

    vga_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .io_in0_awvalid(in_awvalid[0]), .io_in0_awready(in_awready[0]),
        .io_in0_awaddr(in_awaddr[0]), .io_in0_awid(in_awid[0]),
        .io_in0_awlen(in_awlen[0]), .io_in0_awsize(in_awsize[0]),
        .io_in0_awburst(in_awburst[0]),
        .io_in0_wvalid(in_wvalid[0]), .io_in0_wready(in_wready[0]),
        .io_in0_wdata(in_wdata[0]), .io_in0_wstrb(in_wstrb[0]),
        .io_in0_wlast(in_wlast[0]),
        .io_in0_bvalid(in_bvalid[0]), .io_in0_bready(in_bready[0]),
        .io_in0_bresp(in_bresp[0]), .io_in0_bid(in_bid[0]),
        .io_in0_arvalid(in_arvalid[0]), .io_in0_arready(in_arready[0]),
        .io_in0_araddr(in_araddr[0]), .io_in0_arid(in_arid[0]),
        .io_in0_arlen(in_arlen[0]), .io_in0_arsize(in_arsize[0]),
        .io_in0_arburst(in_arburst[0]),
        .io_in0_rvalid(in_rvalid[0]), .io_in0_rready(in_rready[0]),
        .io_in0_rresp(in_rresp[0]), .io_in0_rdata(in_rdata[0]),
        .io_in0_rlast(in_rlast[0]), .io_in0_rid(in_rid[0]),
        .io_in1_awvalid(in_awvalid[1]), .io_in1_awready(in_awready[1]),
        .io_in1_awaddr(in_awaddr[1]), .io_in1_awid(in_awid[1]),
        .io_in1_awlen(in_awlen[1]), .io_in1_awsize(in_awsize[1]),
        .io_in1_awburst(in_awburst[1]),
        .io_in1_wvalid(in_wvalid[1]), .io_in1_wready(in_wready[1]),
        .io_in1_wdata(in_wdata[1]), .io_in1_wstrb(in_wstrb[1]),
        .io_in1_wlast(in_wlast[1]),
        .io_in1_bvalid(in_bvalid[1]), .io_in1_bready(in_bready[1]),
        .io_in1_bresp(in_bresp[1]), .io_in1_bid(in_bid[1]),
        .io_in1_arvalid(in_arvalid[1]), .io_in1_arready(in_arready[1]),
        .io_in1_araddr(in_araddr[1]), .io_in1_arid(in_arid[1]),
        .io_in1_arlen(in_arlen[1]), .io_in1_arsize(in_arsize[1]),
        .io_in1_arburst(in_arburst[1]),
        .io_in1_rvalid(in_rvalid[1]), .io_in1_rready(in_rready[1]),
        .io_in1_rresp(in_rresp[1]), .io_in1_rdata(in_rdata[1]),
        .io_in1_rlast(in_rlast[1]), .io_in1_rid(in_rid[1]),
        .io_out_awvalid(io_out_awvalid), .io_out_awready(io_out_awready),
        .io_out_awaddr(io_out_awaddr), .io_out_awid(io_out_awid),
        .io_out_awlen(io_out_awlen), .io_out_awsize(io_out_awsize),
        .io_out_awburst(io_out_awburst),
        .io_out_wvalid(io_out_wvalid), .io_out_wready(io_out_wready),
        .io_out_wdata(io_out_wdata), .io_out_wstrb(io_out_wstrb),
        .io_out_wlast(io_out_wlast),
        .io_out_bvalid(io_out_bvalid), .io_out_bready(io_out_bready),
        .io_out_bresp(io_out_bresp), .io_out_bid(io_out_bid),
        .io_out_arvalid(io_out_arvalid), .io_out_arready(io_out_arready),
        .io_out_araddr(io_out_araddr), .io_out_arid(io_out_arid),
        .io_out_arlen(io_out_arlen), .io_out_arsize(io_out_arsize),
        .io_out_arburst(io_out_arburst),
        .io_out_rvalid(io_out_rvalid), .io_out_rready(io_out_rready),
        .io_out_rresp(io_out_rresp), .io_out_rdata(io_out_rdata),
        .io_out_rlast(io_out_rlast), .io_out_rid(io_out_rid),
        .io_busy(io_busy), .io_grant(io_grant)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
    } addr_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  resp;
    } beat_t;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
        bit          stall;
        int          exp_grant;
    } vec_t;

    addr_t aq[$];
    beat_t rq[$];
    beat_t bq[$];
    logic [63:0] wq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rpat(input logic [31:0] a, input int b);
        return {a, 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    task automatic clear_all();
        for (int p = 0; p < 2; p++) begin
            in_awvalid[p] = 0; in_awaddr[p] = 0; in_awid[p] = 0;
            in_awlen[p] = 0; in_awsize[p] = 0; in_awburst[p] = 0;
            in_wvalid[p] = 0; in_wdata[p] = 0; in_wstrb[p] = 0;
            in_wlast[p] = 0; in_bready[p] = 0;
            in_arvalid[p] = 0; in_araddr[p] = 0; in_arid[p] = 0;
            in_arlen[p] = 0; in_arsize[p] = 0; in_arburst[p] = 0;
            in_rready[p] = 0;
        end
        io_out_awready = 0; io_out_wready = 0; io_out_arready = 0;
        io_out_bvalid = 0; io_out_bresp = 0; io_out_bid = 0;
        io_out_rvalid = 0; io_out_rresp = 0; io_out_rdata = 0;
        io_out_rlast = 0; io_out_rid = 0;
    endtask

    // Starts at a negedge with the DUT idle; ends at the bubble cycle.
    task automatic do_read(input int p, input logic [31:0] addr,
                           input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] resp, input bit stall,
                           input bit pre, input int abort_at,
                           input int exp_g);
        int n;
        addr_t a;
        beat_t e;
        if (!pre) begin
            in_arvalid[p] = 1; in_araddr[p] = addr; in_arid[p] = id;
            in_arlen[p] = len; in_arsize[p] = 3; in_arburst[p] = 1;
        end
        aq.push_back('{addr, id, len});
        for (int b = 0; b <= int'(len); b++)
            rq.push_back('{rpat(addr, b), b == int'(len), id, resp});
        io_out_arready = 1;
        n = 0;
        do begin
            @(negedge clock); #1; n++;
        end while (!io_out_arvalid && n < 20);
        chk("ar_latency", n, 1);
        a = aq.pop_front();
        chk("out_araddr", io_out_araddr, a.addr);
        chk("out_arid", io_out_arid, a.id);
        chk("out_arlen", io_out_arlen, a.len);
        chk("out_arburst", io_out_arburst, 1);
        chk("rd_grant", io_grant, exp_g);
        chk("in_arready", in_arready[p], 1);
        chk("other_arready", in_arready[1-p], 0);
        @(negedge clock);
        in_arvalid[p] = 0; io_out_arready = 0;
        for (int b = 0; b <= int'(len); b++) begin
            io_out_rvalid = 1; io_out_rdata = rpat(addr, b);
            io_out_rlast = (b == int'(len)); io_out_rid = id;
            io_out_rresp = resp;
            in_rready[p] = !(stall && b == 0);
            if (b == abort_at) begin
                reset = 1;
                @(negedge clock);
                reset = 0;
                rq.delete();
                return;
            end
            #1;
            if (stall && b == 0) begin
                chk("rready_bp", io_out_rready, 0);
                @(negedge clock);
                in_rready[p] = 1;
                #1;
            end
            chk("in_rvalid", in_rvalid[p], 1);
            chk("other_rvalid", in_rvalid[1-p], 0);
            chk("rq_nonempty", rq.size() != 0, 1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                chk("rdata", in_rdata[p], e.data);
                chk("rlast", in_rlast[p], e.last);
                chk("rid", in_rid[p], e.id);
                chk("rresp", in_rresp[p], e.resp);
            end
            @(negedge clock);
        end
        io_out_rvalid = 0; io_out_rlast = 0; in_rready[p] = 0;
        #1;
        chk("rd_bubble_busy", io_busy, 0);
    endtask

    task automatic do_write(input int p, input logic [31:0] addr,
                            input logic [3:0] id, input logic [7:0] len,
                            input logic [63:0] data, input logic [7:0] strb,
                            input logic [1:0] resp, input bit stall,
                            input int exp_g);
        int n;
        addr_t a;
        beat_t e;
        in_awvalid[p] = 1; in_awaddr[p] = addr; in_awid[p] = id;
        in_awlen[p] = len; in_awsize[p] = 3; in_awburst[p] = 1;
        in_wvalid[p] = 1; in_wdata[p] = data; in_wstrb[p] = strb;
        in_wlast[p] = (len == 0);
        aq.push_back('{addr, id, len});
        for (int b = 0; b <= int'(len); b++) wq.push_back(data + 64'(b));
        bq.push_back('{64'd0, 1'b1, id, resp});
        io_out_awready = 1;
        n = 0;
        do begin
            @(negedge clock); #1; n++;
        end while (!io_out_awvalid && n < 20);
        chk("aw_latency", n, 1);
        a = aq.pop_front();
        chk("out_awaddr", io_out_awaddr, a.addr);
        chk("out_awid", io_out_awid, a.id);
        chk("out_awlen", io_out_awlen, a.len);
        chk("wr_grant", io_grant, exp_g);
        chk("w_before_aw", io_out_wvalid, 0);
        chk("wready_before_aw", in_wready[p], 0);
        chk("ar_held_off", io_out_arvalid, 0);
        @(negedge clock);
        in_awvalid[p] = 0; io_out_awready = 0;
        for (int b = 0; b <= int'(len); b++) begin
            in_wdata[p] = data + 64'(b);
            in_wlast[p] = (b == int'(len));
            io_out_wready = !(stall && b == 0);
            #1;
            if (stall && b == 0) begin
                chk("wready_bp", in_wready[p], 0);
                @(negedge clock);
                io_out_wready = 1;
                #1;
            end
            chk("out_wvalid", io_out_wvalid, 1);
            chk("in_wready", in_wready[p], 1);
            chk("out_wdata", io_out_wdata, wq.pop_front());
            chk("out_wstrb", io_out_wstrb, strb);
            chk("out_wlast", io_out_wlast, b == int'(len));
            chk("ar_held_w", io_out_arvalid, 0);
            @(negedge clock);
        end
        in_wvalid[p] = 0; in_wlast[p] = 0; io_out_wready = 0;
        io_out_bvalid = 1; io_out_bresp = resp; io_out_bid = id;
        in_bready[p] = 1;
        #1;
        e = bq.pop_front();
        chk("in_bvalid", in_bvalid[p], 1);
        chk("other_bvalid", in_bvalid[1-p], 0);
        chk("bresp", in_bresp[p], e.resp);
        chk("bid", in_bid[p], e.id);
        chk("out_bready", io_out_bready, 1);
        @(negedge clock);
        io_out_bvalid = 0; in_bready[p] = 0;
        #1;
        chk("wr_bubble_busy", io_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int cnt, ng, eg, bad;
        vecs[0] = '{0, 0, 32'h8000_0000, 4'h3, 8'd3, 64'h0, 8'h00, 2'd0, 0, 0};
        vecs[1] = '{1, 1, 32'h8010_0040, 4'h5, 8'd0,
                    64'hDEAD_BEEF_0123_4567, 8'hFF, 2'd0, 0, 1};
        vecs[2] = '{1, 0, 32'h8020_0000, 4'h9, 8'd1, 64'h0, 8'h00, 2'd2, 1, 1};
        vecs[3] = '{0, 1, 32'h8000_1000, 4'h1, 8'd2,
                    64'h1111_2222_3333_4444, 8'h0F, 2'd2, 1, 0};
        vecs[4] = '{1, 0, 32'h8030_0008, 4'hF, 8'd0, 64'h0, 8'h00, 2'd0, 0, 1};
        vecs[5] = '{0, 1, 32'h8040_0000, 4'h7, 8'd0,
                    64'hCAFE_F00D_0000_0001, 8'h80, 2'd1, 0, 0};

        clear_all();
        repeat (3) @(negedge clock);
        // requests and memory readiness present while reset is held
        in_arvalid[1] = 1; in_awvalid[0] = 1;
        io_out_arready = 1; io_out_awready = 1;
        @(negedge clock); #1;
        chk("rst_out_valids", {io_out_arvalid, io_out_awvalid,
                               io_out_wvalid}, 0);
        chk("rst_in_readies", {in_arready[1], in_awready[0],
                               in_wready[0]}, 0);
        chk("rst_busy", io_busy, 0);
        chk("rst_grant", io_grant, 0);
        chk("rst_starve", dut.starve_cnt_q, 0);
        clear_all();
        reset = 0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].port, vecs[i].addr, vecs[i].id,
                         vecs[i].len, vecs[i].data, vecs[i].strb,
                         vecs[i].resp, vecs[i].stall, vecs[i].exp_grant);
            else
                do_read(vecs[i].port, vecs[i].addr, vecs[i].id,
                        vecs[i].len, vecs[i].resp, vecs[i].stall,
                        0, -1, vecs[i].exp_grant);
        end

        // port 0 presents AW and AR together: the write must finish first
        in_arvalid[0] = 1; in_araddr[0] = 32'h8000_2000; in_arid[0] = 4'h2;
        in_arlen[0] = 8'd1; in_arsize[0] = 3; in_arburst[0] = 1;
        do_write(0, 32'h8000_3000, 4'h4, 8'd0, 64'h0BAD_C0DE_0000_0042,
                 8'hFF, 2'd0, 0, 0);
        do_read(0, 32'h8000_2000, 4'h2, 8'd1, 2'd0, 0, 1, -1, 0);

        // reset during beat 2 of an 8-beat read on port 1
        do_read(1, 32'h8050_0000, 4'hA, 8'd7, 2'd0, 0, 0, 1, 1);
        #1;
        chk("midrst_out", {io_out_arvalid, io_out_awvalid, io_out_wvalid,
                           io_out_rready, io_out_bready}, 0);
        chk("midrst_in", {in_rvalid[0], in_rvalid[1], in_bvalid[0],
                          in_bvalid[1], in_arready[0], in_arready[1],
                          in_awready[0], in_awready[1]}, 0);
        chk("midrst_busy", io_busy, 0);
        chk("midrst_grant", io_grant, 0);
        clear_all();
        @(negedge clock);
        do_read(0, 32'h8060_0000, 4'h6, 8'd0, 2'd0, 0, 0, -1, 0);
        do_read(1, 32'h8070_0000, 4'hB, 8'd2, 2'd0, 0, 0, -1, 1);

        // both ports request without pause
        for (int p = 0; p < 2; p++) begin
            in_arvalid[p] = 1; in_araddr[p] = 32'h9000_0000 + 32'(p);
            in_arid[p] = 4'(p); in_arlen[p] = 0; in_rready[p] = 1;
        end
        io_out_arready = 1; io_out_rvalid = 1; io_out_rlast = 1;
        cnt = 0; ng = 0; bad = 0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            @(negedge clock); #1;
            if (io_out_arvalid) begin
                eg = (cnt == 4) ? 1 : 0;
                cnt = eg ? 0 : cnt + 1;
                chk("grant_seq", io_grant, eg);
                chk("loser_arready", in_arready[1-eg], 0);
                chk("granted_addr", io_out_araddr,
                    32'h9000_0000 + 32'(eg));
                ng++;
            end else if (io_busy) begin
                bad += int'(in_rvalid[0] & in_rvalid[1]);
            end
        end
        chk("grant_count", ng, 10);
        chk("rvalid_exclusive", bad, 0);
        @(negedge clock);
        in_arvalid[0] = 0; in_arvalid[1] = 0;
        @(negedge clock);
        clear_all();
        #1;
        chk("cont_end_busy", io_busy, 0);

        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock); #1;
            bad += int'(io_out_arvalid | io_out_awvalid | io_out_wvalid |
                        io_busy | (dut.starve_cnt_q != 0));
        end
        chk("idle_isolation", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
